wb_port_arbiter: RTL

Shares the register file's single write-back port between the pipeline write-back stage and a multi-cycle unit such as a multiplier or long-latency load. The pipeline write-back normally has priority. An aging counter bounds how long the multi-cycle unit can starve, and a one-entry skid buffer absorbs a pipeline write displaced by a forced grant. The block sits between the WB stage / multi-cycle unit and the register file write inputs, and drives them from registers.

---
 rtl/wb_port_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the register file's single write-back port between the pipeline
// write-back stage and a multi-cycle unit (multiplier / long-latency load).
// The pipeline normally wins. An aging counter force-grants a multi-cycle
// request after MAX_WAIT lost arbitrations, and a one-entry skid buffer holds
// the pipeline write displaced by that forced grant.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   wb_en/wb_dest/wb_result      pipeline write-back request
//   mul_valid/mul_dest/mul_result multi-cycle request (held until mul_ready)
//   mul_ready                    combinational accept for the multi-cycle request
//   writeBackEn/Dest_wb/Result_WB registered register-file write port
//   pipe_stall                   skid occupied; pipeline must hold off wb_en
//   drop_cnt                     saturating count of discarded multi-cycle writes
//   err_overrun                  sticky: wb_en seen while pipe_stall was high
module wb_port_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en,
  input  logic [3:0]  wb_dest,
  input  logic [31:0] wb_result,
  input  logic        mul_valid,
  input  logic [3:0]  mul_dest,
  input  logic [31:0] mul_result,
  output logic        mul_ready,
  output logic        writeBackEn,
  output logic [3:0]  Dest_wb,
  output logic [31:0] Result_WB,
  output logic        pipe_stall,
  output logic [7:0]  drop_cnt,
  output logic        err_overrun
);

  localparam logic [3:0] MW = 4'(MAX_WAIT);

  logic        skid_valid;
  logic [3:0]  skid_dest;
  logic [31:0] skid_data;
  logic [3:0]  wait_cnt;

  logic collide, force_grant, mul_grant;

  // Same-destination collision: the pipeline value is newer, so the
  // multi-cycle write is acknowledged and thrown away.
  assign collide     = wb_en && mul_valid && (mul_dest == wb_dest);
  assign force_grant = (wait_cnt == MW);
  assign mul_grant   = mul_valid && (!wb_en || force_grant);

  always_comb begin
    mul_ready = 1'b0;
    if (!rst && !skid_valid)
      mul_ready = collide || mul_grant;
  end

  assign pipe_stall = skid_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      writeBackEn <= 1'b0;
      Dest_wb     <= '0;
      Result_WB   <= '0;
      skid_valid  <= 1'b0;
      skid_dest   <= '0;
      skid_data   <= '0;
      wait_cnt    <= '0;
      drop_cnt    <= '0;
      err_overrun <= 1'b0;
    end else if (skid_valid) begin
      // Drain the displaced pipeline write first; it must land after the
      // forced multi-cycle write that displaced it.
      writeBackEn <= 1'b1;
      Dest_wb     <= skid_dest;
      Result_WB   <= skid_data;
      skid_valid  <= 1'b0;
      if (mul_valid && !force_grant) wait_cnt <= wait_cnt + 4'd1;
      if (wb_en) err_overrun <= 1'b1;
    end else if (collide) begin
      writeBackEn <= 1'b1;
      Dest_wb     <= wb_dest;
      Result_WB   <= wb_result;
      wait_cnt    <= '0;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else if (mul_grant) begin
      writeBackEn <= 1'b1;
      Dest_wb     <= mul_dest;
      Result_WB   <= mul_result;
      wait_cnt    <= '0;
      if (wb_en) begin
        skid_valid <= 1'b1;
        skid_dest  <= wb_dest;
        skid_data  <= wb_result;
      end
    end else if (wb_en) begin
      writeBackEn <= 1'b1;
      Dest_wb     <= wb_dest;
      Result_WB   <= wb_result;
      if (!mul_valid)        wait_cnt <= '0;
      else if (!force_grant) wait_cnt <= wait_cnt + 4'd1;
    end else begin
      // Idle: address/data hold their last values.
      writeBackEn <= 1'b0;
      wait_cnt    <= '0;
    end
  end

endmodule
